imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the byte-serial instruction-memory loader:
//   loader_state_t : frame-parser states
//   LOADER_HDR     : byte that opens every frame
//   WORD_BYTES     : bytes assembled into one instruction word
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CSUM  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    localparam logic [7:0] LOADER_HDR = 8'hA5;
    localparam int         WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// imem_loader
// Receives a framed program image byte by byte, assembles little-endian
// 32-bit instructions and writes them into the instruction memory. The
// processor is held in reset for the whole load, and stays held if the
// image turns out to be corrupt.
//
// Frame: A5, N (words), 4*N data bytes LSB first, checksum C, where
// (sum of data bytes + C) mod 256 must be zero.
//
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   rx_valid  in   one-cycle strobe, rx_data holds a byte
//   rx_data   in   received byte
//   we        out  one-cycle instruction-memory write enable
//   waddr     out  word-aligned byte address of the write
//   wdata     out  instruction word being written
//   cpu_hold  out  keeps the processor in reset while high
//   done      out  one-cycle pulse when a frame checks out
//   err       out  sticky frame error, cleared by the next header
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32,
    parameter int TIMEOUT     = 1_000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   we,
    output logic [INS_ADDRESS-1:0] waddr,
    output logic [INS_W-1:0]       wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam int         DEPTH     = 2 ** (INS_ADDRESS - 2);
    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    loader_state_t state_q, state_d;

    logic [7:0]             count_q, count_d;
    logic [7:0]             idx_q, idx_d;
    logic [1:0]             lane_q, lane_d;
    logic [7:0]             sum_q, sum_d;
    logic [23:0]            asm_q, asm_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   we_q, we_d;
    logic [INS_ADDRESS-1:0] waddr_q, waddr_d;
    logic [INS_W-1:0]       wdata_q, wdata_d;
    logic                   hold_q, hold_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic inFrame;
    logic timeoutHit;

    // The inter-byte timer only runs while a frame is open; once it has
    // counted TIMEOUT idle cycles the frame is abandoned. A byte arriving
    // in the expiry cycle takes priority and reloads the timer.
    assign inFrame    = (state_q == COUNT) || (state_q == DATA) || (state_q == CSUM);
    assign timeoutHit = (timer_q == TW'(TIMEOUT - 1));

    // Next-state and output logic. Everything holds by default; we and
    // done are pulses so they default low. The assembly register shifts
    // bytes in from the top so after three bytes it holds {b2,b1,b0} and
    // the fourth byte completes the word as its most significant byte.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        sum_d   = sum_q;
        asm_d   = asm_q;
        timer_d = '0;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE, ERR: begin
                if (rx_valid && rx_data == LOADER_HDR) begin
                    state_d = COUNT;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end

            COUNT: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        count_d = rx_data;
                        idx_d   = 8'd0;
                        lane_d  = 2'd0;
                        sum_d   = 8'd0;
                        state_d = DATA;
                    end
                end
            end

            DATA: begin
                if (rx_valid) begin
                    sum_d  = sum_q + rx_data;
                    asm_d  = {rx_data, asm_q[23:8]};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == LAST_LANE) begin
                        we_d    = 1'b1;
                        waddr_d = INS_ADDRESS'({idx_q, 2'b00});
                        wdata_d = INS_W'({rx_data, asm_q});
                        idx_d   = idx_q + 8'd1;
                        if ((idx_q + 8'd1) == count_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end

            CSUM: begin
                if (rx_valid) begin
                    if ((sum_q + rx_data) == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (inFrame && !rx_valid) begin
            if (timeoutHit) begin
                state_d = ERR;
                err_d   = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // State and output registers with synchronous reset; a reset mid-frame
    // drops the parser back to IDLE so no further writes are issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            sum_q   <= '0;
            asm_q   <= '0;
            timer_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            sum_q   <= sum_d;
            asm_q   <= asm_d;
            timer_q <= timer_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader. Expected writes are queued when a
// frame is issued; a monitor on the falling edge pops and compares every
// write the loader presents, and counts done pulses.
module tb_imem_loader;

    localparam int AW    = 9;
    localparam int TO    = 40;
    localparam int DEPTH = 2 ** (AW - 2);

    logic          clk;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t expQ[$];
    int  checks    = 0;
    int  errors    = 0;
    int  doneSeen  = 0;
    int  doneExp   = 0;

    imem_loader #(
        .INS_ADDRESS(AW),
        .INS_W      (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .cpu_hold(cpu_hold),
        .done    (done),
        .err     (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by the stimulus and monitor processes.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one byte for a single cycle, then leaves gap idle cycles.
    // Called at posedge+1 and returns at posedge+1.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: from a word list decide which writes must happen,
    // what checksum makes the frame valid, and whether done is due. Then
    // send the frame and verify the final status flags.
    task automatic sendFrame(input int n, input logic [31:0] w[$], input bit badSum, input int maxGap);
        logic [7:0] sum;
        logic [7:0] csum;
        logic [31:0] word;
        bit countOk;
        bit expectOk;
        countOk  = (n >= 1) && (n <= DEPTH);
        expectOk = countOk && !badSum;
        sum = 8'd0;
        if (countOk) begin
            for (int i = 0; i < n; i++) begin
                expQ.push_back('{addr: AW'(i * 4), data: w[i]});
                word = w[i];
                sum = sum + word[7:0] + word[15:8] + word[23:16] + word[31:24];
            end
        end
        csum = 8'(256 - int'(sum));
        if (badSum) csum = csum + 8'd1 + 8'($urandom_range(0, 200));
        if (expectOk) doneExp++;

        applyStimulus(8'hA5, 0);
        checkOutput("hold_after_hdr", {31'b0, cpu_hold}, 32'd1);
        checkOutput("err_clear_on_hdr", {31'b0, err}, 32'd0);
        applyStimulus(8'(n), $urandom_range(0, maxGap));
        if (countOk) begin
            for (int i = 0; i < n; i++) begin
                word = w[i];
                for (int b = 0; b < 4; b++) begin
                    applyStimulus(word[b*8 +: 8], $urandom_range(0, maxGap));
                end
            end
            applyStimulus(csum, 0);
        end
        idle(2);
        checkOutput("frame_err", {31'b0, err}, {31'b0, !expectOk});
        checkOutput("frame_hold", {31'b0, cpu_hold}, {31'b0, !expectOk});
        checkOutput("done_count", doneSeen, doneExp);
    endtask

    // Monitor: every write must match the head of the expected queue and
    // must occur while the processor is held.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_we", {31'b0, we}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("waddr", {{(32-AW){1'b0}}, waddr}, {{(32-AW){1'b0}}, e.addr});
                    checkOutput("wdata", wdata, e.data);
                    checkOutput("hold_during_we", {31'b0, cpu_hold}, 32'd1);
                end
            end
            if (done === 1'b1) doneSeen++;
        end
    end

    // Watchdog so a stuck run still ends with a visible failure.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios first, then randomized frames.
    initial begin
        logic [31:0] w[$];
        int n;
        bit bad;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", {31'b0, we}, 32'd0);
        checkOutput("rst_waddr", {{(32-AW){1'b0}}, waddr}, 32'd0);
        checkOutput("rst_wdata", wdata, 32'd0);
        checkOutput("rst_hold", {31'b0, cpu_hold}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        idle(2);

        $display("[TB] basic two-word frame");
        expQ.push_back('{addr: AW'(0), data: 32'h00007033});
        expQ.push_back('{addr: AW'(4), data: 32'h00500293});
        doneExp++;
        applyStimulus(8'hA5, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h33, 1);
        applyStimulus(8'h70, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h93, 1);
        applyStimulus(8'h02, 1);
        applyStimulus(8'h50, 1);
        applyStimulus(8'h00, 1);
        applyStimulus(8'h78, 0);
        checkOutput("basic_done_pulse", {31'b0, done}, 32'd1);
        checkOutput("basic_hold_fall", {31'b0, cpu_hold}, 32'd0);
        idle(2);
        checkOutput("basic_done", doneSeen, doneExp);
        checkOutput("basic_err", {31'b0, err}, 32'd0);

        $display("[TB] bad checksum then recovery");
        expQ.push_back('{addr: AW'(0), data: 32'h00007033});
        expQ.push_back('{addr: AW'(4), data: 32'h00500293});
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h70, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h93, 0);
        applyStimulus(8'h02, 0);
        applyStimulus(8'h50, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h79, 0);
        checkOutput("badsum_err", {31'b0, err}, 32'd1);
        idle(3);
        checkOutput("badsum_hold", {31'b0, cpu_hold}, 32'd1);
        checkOutput("badsum_no_done", doneSeen, doneExp);
        w = '{32'h00007033, 32'h00500293};
        sendFrame(2, w, 1'b0, 2);

        $display("[TB] garbage then zero count");
        applyStimulus(8'h12, 0);
        applyStimulus(8'h34, 0);
        checkOutput("garbage_hold", {31'b0, cpu_hold}, 32'd0);
        w = '{};
        sendFrame(0, w, 1'b0, 0);

        $display("[TB] timeout inside frame");
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h33, 0);
        applyStimulus(8'h70, 0);
        idle(TO - 3);
        checkOutput("pre_timeout_err", {31'b0, err}, 32'd0);
        idle(6);
        checkOutput("timeout_err", {31'b0, err}, 32'd1);
        checkOutput("timeout_hold", {31'b0, cpu_hold}, 32'd1);

        $display("[TB] full-rate maximum image");
        w = '{};
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom());
        sendFrame(DEPTH, w, 1'b0, 0);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'h33, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_hold", {31'b0, cpu_hold}, 32'd0);
        checkOutput("midrst_err", {31'b0, err}, 32'd0);
        reset = 1'b0;
        applyStimulus(8'h70, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        idle(3);
        checkOutput("midrst_no_done", doneSeen, doneExp);
        checkOutput("midrst_hold_after", {31'b0, cpu_hold}, 32'd0);

        $display("[TB] randomized frames");
        for (int f = 0; f < 10; f++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                rx_data = 8'($urandom());
                if (rx_data == 8'hA5) rx_data = 8'h5A;
                applyStimulus(rx_data, 0);
            end
            if ($urandom_range(0, 7) == 0) n = DEPTH + 1 + $urandom_range(0, 100);
            else n = $urandom_range(1, 8);
            bad = ($urandom_range(0, 3) == 0);
            w = '{};
            for (int i = 0; i < n && i < DEPTH; i++) w.push_back($urandom());
            sendFrame(n, w, bad, 3);
        end

        idle(4);
        checkOutput("sb_empty", expQ.size(), 32'd0);
        checkOutput("final_done", doneSeen, doneExp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
